rom_stream_reader: RTL and testbench
====================================

ROM_STREAM_READER -- requirements
Module: rom_stream_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 4: ROM word count, power of two, at least 2.
REQ-002 SHALL have parameter ADDR_W, default 2: ROM address width, equal to log2(DEPTH).
REQ-003 SHALL have parameter DATA_W, default 5: ROM word width.
REQ-004 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESETN, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1: burst request; sampled in IDLE only.
REQ-007 SHALL have port base, input, ADDR_W: first ROM address of the burst; sampled with start.
REQ-008 SHALL have port len, input, ADDR_W+1: words in the burst, range 0..DEPTH; sampled with start.
REQ-009 SHALL have port RADDR, output, ADDR_W: ROM read address.
REQ-010 SHALL have port RDATA, input, DATA_W: ROM read data.
REQ-011 SHALL have port out_valid, output, 1: out_data holds a word.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts a word.
REQ-013 SHALL have port out_data, output, DATA_W: streamed ROM word.
REQ-014 SHALL have port busy, output, 1: burst in progress.
REQ-015 SHALL have port done, output, 1: one-cycle burst-complete pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-017 SHALL, in IDLE with start=1, latch base and len, then go to RUN; len=0 SHALL instead give done=1 on the next cycle and stay in IDLE.
REQ-018 SHALL ignore start in RUN and DRAIN, with no effect on the current burst.
REQ-019 SHALL hold RADDR = next address to read; RADDR SHALL start at base and advance by 1 modulo DEPTH per issued read (DEPTH-1 wraps to 0).
REQ-020 SHALL buffer words in a 2-entry FIFO; out_valid SHALL be 1 exactly when the FIFO is non-empty; out_data SHALL be the head entry.
REQ-021 SHALL count a transfer when out_valid=1 and out_ready=1; the head SHALL pop on that edge.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL issue a read in RUN only when FIFO occupancy plus in-flight reads, minus a pop in the same cycle, is below 2; simultaneous push and pop on a full FIFO SHALL be legal.
REQ-024 SHALL go from RUN to DRAIN when the len-th read issues, and from DRAIN to IDLE when the last word pops.
REQ-025 SHALL assert done for exactly the cycle after the last word's transfer edge.
REQ-026 SHALL assert busy from the cycle after start is accepted until IDLE is re-entered, and deassert busy in the cycle done=1.
REQ-027 SHALL give one-cycle start-to-out_valid latency without the macro and two cycles with it, when out_ready=1 throughout.
REQ-028 SHALL, with out_ready=1 throughout, sustain one word per cycle in both modes.
REQ-029 SHALL, for len=DEPTH, read every ROM address exactly once, starting at base.

Reset
REQ-030 SHALL, with RESETN=0 at a rising edge, enter IDLE, empty the FIFO, clear in-flight reads and set RADDR=0, out_valid=0, busy=0, done=0 and out_data=0.
REQ-031 SHALL, when reset occurs mid-burst, discard all buffered and in-flight words with no done pulse.
REQ-032 SHALL ignore start while RESETN=0.

Configuration
REQ-033 SHALL use macro ROM_STREAM_READER_SYNC_READ_EN to select the ROM read timing.
REQ-034 SHALL, when ROM_STREAM_READER_SYNC_READ_EN is undefined, treat RDATA as combinational from RADDR and push it into the FIFO on the same edge the read issues.
REQ-035 SHALL, when ROM_STREAM_READER_SYNC_READ_EN is defined, treat RDATA as valid one cycle after issue, track in-flight reads, and push RDATA on the following edge.

Verification
ROM contents for all scenarios: addr0=5, addr1=0, addr2=21, addr3=11.
REQ-036 SHALL cover: start with base=0, len=4, out_ready=1 -> out_data 5, 0, 21, 11 on consecutive cycles, then done for one cycle.
REQ-037 SHALL cover: start with base=3, len=3 -> out_data 11, 5, 0 (address wrap).
REQ-038 SHALL cover: base=1, len=4, out_ready=0 for 5 cycles then 1 -> out_data held at 0 while stalled, RADDR=3 held, no word lost or duplicated, sequence 0, 21, 11, 5.
REQ-039 SHALL cover: len=0 -> done=1 on the next cycle, busy stays 0, out_valid stays 0.
REQ-040 SHALL cover: RESETN=0 after the second transfer of a len=4 burst -> out_valid=0 and busy=0 next cycle, no done; a new burst with base=2, len=1 then returns 21.
REQ-041 SHALL cover: start pulsed during RUN -> no effect; word count stays 4.

Source files
------------

// File: rtl/rom_stream_reader.sv
// Streams a burst of ROM words through a 2-entry FIFO with valid/ready output handshake.
// Define ROM_STREAM_READER_SYNC_READ_EN for a ROM with one-cycle registered read data.
module rom_stream_reader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 5
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] RADDR,
  input  logic [DATA_W-1:0] RDATA,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W:0]   rd_left;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              rd_pending;

  logic              issue;
  logic              pop;
  logic              push;
  logic              last_pop;
  logic [DATA_W-1:0] push_data;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] next_addr;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    pop       = out_valid && out_ready;
    occupancy = {1'b0, count} + {2'b00, rd_pending};
    issue     = (state == RUN) && ((occupancy - {2'b00, pop}) < 3'd2);
    next_addr = (RADDR == LAST_ADDR) ? '0 : RADDR + 1'b1;
    push_data = RDATA;
`ifdef ROM_STREAM_READER_SYNC_READ_EN
    push      = rd_pending;
`else
    push      = issue;
`endif
    // A pending sync read would refill the FIFO on this edge, so it is not the last pop.
    last_pop  = (state == DRAIN) && pop && (count == 2'd1) && !rd_pending;
  end

  // NOTE: reset is synchronous, sampled only on the rising clock edge.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state       <= IDLE;
      RADDR       <= '0;
      rd_left     <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
      rd_pending  <= 1'b0;
      done        <= 1'b0;
      // NOTE: the two FIFO entries are reset so out_data reads 0 after reset.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state   <= RUN;
              RADDR   <= base;
              rd_left <= len;
            end
          end
        end
        RUN: begin
          if (issue && (rd_left == 1)) state <= DRAIN;
        end
        DRAIN: begin
          if (last_pop) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        RADDR   <= next_addr;
        rd_left <= rd_left - 1'b1;
      end

      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};

`ifdef ROM_STREAM_READER_SYNC_READ_EN
      rd_pending <= issue;
`else
      rd_pending <= 1'b0;
`endif
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader against a 4-word ROM (5, 0, 21, 11).
// Follows ROM_STREAM_READER_SYNC_READ_EN for the ROM model and expected latency.
module tb_rom_stream_reader;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       start;
  logic [1:0] base;
  logic [2:0] len;
  logic [1:0] RADDR;
  logic [4:0] RDATA;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] rom [4];
  initial begin
    rom[0] = 5'd5; rom[1] = 5'd0; rom[2] = 5'd21; rom[3] = 5'd11;
  end

`ifdef ROM_STREAM_READER_SYNC_READ_EN
  localparam int LAT = 2;
  always @(posedge CLK) RDATA <= rom[RADDR];
`else
  localparam int LAT = 1;
  assign RDATA = rom[RADDR];
`endif

  rom_stream_reader #(.DEPTH(4), .ADDR_W(2), .DATA_W(5)) dut (
    .CLK(CLK), .RESETN(RESETN), .start(start), .base(base), .len(len),
    .RADDR(RADDR), .RDATA(RDATA), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Results of the most recent burst.
  logic [4:0] got [$];
  int         done_cnt;
  int         first_valid;
  int         done_cyc;
  int         hold_err;
  logic       busy1;
  logic       busy_at_done;
  logic [1:0] stall_raddr;
  logic [4:0] stall_data;

  // Cycle 0 presents start; out_ready is low for cycles 0..stall-1.
  task automatic burst(input logic [1:0] b, input logic [2:0] l, input int stall, input int poke_cyc);
    logic       prev_stall;
    logic [4:0] prev_data;
    got.delete();
    done_cnt = 0; first_valid = -1; done_cyc = -1; hold_err = 0;
    busy1 = 1'b0; busy_at_done = 1'b1; stall_raddr = '0; stall_data = '0;
    prev_stall = 1'b0; prev_data = '0;
    start = 1'b1; base = b; len = l; out_ready = (stall == 0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) busy1 = busy;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          busy_at_done = busy;
        end
      end
      if (out_valid && first_valid < 0) first_valid = c;
      if (prev_stall && out_valid && out_data != prev_data) hold_err++;
      if (c == stall) begin
        stall_raddr = RADDR;
        stall_data  = out_data;
      end
      out_ready = (c >= stall);
      start = (c == poke_cyc);
      if (c == poke_cyc) begin
        base = 2'd3;
        len  = 3'd1;
      end
      if (out_valid && out_ready) got.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done_cyc > 0 && c >= done_cyc + 2) break;
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_words(input string tag, input int n, input int e0, input int e1,
                             input int e2, input int e3);
    int e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check($sformatf("%s count", tag), got.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s word%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'd999, e[i]);
  endtask

  initial begin
    int xfers;
    int late_done;
    RESETN = 1'b0; start = 1'b1; base = 2'd2; len = 3'd3; out_ready = 1'b1;
    tick(); tick();
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst raddr", RADDR, 0);
    check("rst out_data", out_data, 0);
    start = 1'b0;
    RESETN = 1'b1;
    tick();
    check("rst start ignored", busy, 0);

    // Full burst, ready throughout.
    burst(2'd0, 3'd4, 0, 0);
    check_words("b0l4", 4, 5, 0, 21, 11);
    check("b0l4 busy1", busy1, 1);
    check("b0l4 latency", first_valid, LAT + 1);
    check("b0l4 done cycle", done_cyc, LAT + 5);
    check("b0l4 done pulses", done_cnt, 1);
    check("b0l4 busy at done", busy_at_done, 0);

    // Address wrap.
    tick();
    burst(2'd3, 3'd3, 0, 0);
    check_words("b3l3", 3, 11, 5, 0, 0);
    check("b3l3 done pulses", done_cnt, 1);

    // Stall for five cycles.
    tick();
    burst(2'd1, 3'd4, 5, 0);
    check_words("stall", 4, 0, 21, 11, 5);
    check("stall raddr", stall_raddr, 3);
    check("stall data", stall_data, 0);
    check("stall hold", hold_err, 0);
    check("stall done pulses", done_cnt, 1);

    // Zero-length burst.
    tick();
    start = 1'b1; base = 2'd1; len = 3'd0;
    tick();
    start = 1'b0;
    check("len0 done", done, 1);
    check("len0 busy", busy, 0);
    check("len0 out_valid", out_valid, 0);
    tick();
    check("len0 done clear", done, 0);
    check("len0 busy after", busy, 0);
    check("len0 out_valid after", out_valid, 0);

    // Reset after the second transfer.
    tick();
    start = 1'b1; base = 2'd0; len = 3'd4; out_ready = 1'b1;
    tick();
    start = 1'b0;
    xfers = 0;
    for (int c = 0; c < 20 && xfers < 2; c++) begin
      if (out_valid && out_ready) xfers++;
      tick();
    end
    check("mid rst xfers", xfers, 2);
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    check("mid rst out_valid", out_valid, 0);
    check("mid rst busy", busy, 0);
    check("mid rst done", done, 0);
    late_done = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || out_valid) late_done++;
    end
    check("mid rst no done", late_done, 0);
    burst(2'd2, 3'd1, 0, 0);
    check_words("post rst", 1, 21, 0, 0, 0);
    check("post rst done pulses", done_cnt, 1);

    // Start pulsed during RUN.
    tick();
    burst(2'd0, 3'd4, 0, 2);
    check_words("poke", 4, 5, 0, 21, 11);
    check("poke done pulses", done_cnt, 1);
    check("poke idle after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
